master_state_ctrl: RTL and testbench
====================================

# master_state_ctrl

Top-level game sequencer for the Snake design. Owns the 2-bit `MASTER_STATE` that selects what the VGA display state machine draws (IDLE splash, PLAY field, WIN screen). It advances on user button presses, counts targets eaten and holds the end screen for a fixed time before returning to IDLE.

## Interface
Parameters:
- `WIN_SCORE`, default 10: number of targets eaten that ends the game in WIN. Legal range is 1..255.
- `HOLD_CYCLES`, default 100_000_000: number of CLK cycles the WIN/LOSE screen is held (1 s at 100 MHz).
- `HOLD_W`, default 27: width of the hold counter. Must satisfy 2^HOLD_W > HOLD_CYCLES.

Ports:
- `CLK` in 1: system clock. This is the only clock.
- `RESET` in 1: synchronous, active-high reset.
- `BTNS` in 4: raw direction buttons (U, D, L, R). They are asynchronous to CLK.
- `SCORE_INC` in 1: one-cycle pulse from the snake datapath when a target is eaten.
- `COLLISION` in 1: level from the snake datapath, high while the head overlaps the body or a wall.
- `MASTER_STATE` out 2: IDLE=2'b00, PLAY=2'b01, WIN=2'b10, LOSE=2'b11.
- `SCORE` out 8: current score, registered.
- `SCORE_CLR` out 1: one-cycle pulse when a new game starts. It resets the snake datapath.

## Operation
- Button path:
  - A 2-flop synchronizer per bit, followed by a previous-value register.
  - `btn_edge` = OR over the 4 bits of (sync2 & ~prev).
  - Any rising button edge counts as a "start" event.
- State machine (registered; all transitions occur on the CLK rising edge):
  - IDLE:
    - `btn_edge` moves to PLAY.
    - On that same edge, `SCORE` is set to 0 and `SCORE_CLR` is set to 1 for one cycle.
    - `SCORE_INC` and `COLLISION` are ignored.
  - PLAY:
    - `SCORE_INC` increments `SCORE` by 1.
    - If `SCORE` == WIN_SCORE-1 and `SCORE_INC`=1, `SCORE` becomes WIN_SCORE and the state moves to WIN on the same edge. The hold counter is cleared.
    - `COLLISION`=1 moves to LOSE (see Configuration). The hold counter is cleared. `SCORE` is frozen.
    - If `COLLISION` and a winning `SCORE_INC` occur in the same cycle, LOSE wins. `SCORE` is not incremented.
    - Button edges are ignored.
  - WIN / LOSE:
    - The hold counter increments every cycle.
    - When the counter equals HOLD_CYCLES-1, the next edge moves to IDLE and clears the counter.
    - `SCORE` is held so the end screen can display it.
    - Buttons, `SCORE_INC` and `COLLISION` are ignored.
- `SCORE` saturates at WIN_SCORE and never wraps.
- Reset values: `MASTER_STATE`=IDLE, `SCORE`=0, `SCORE_CLR`=0, hold counter=0, synchronizer and prev flops=0.
- Asserting `RESET` in any state returns to IDLE on that edge. The current game is abandoned with no `SCORE_CLR` pulse.

## Timing
- Button latency: `BTNS` high before edge n gives sync1 at n, sync2 at n+1, and `MASTER_STATE`=PLAY plus `SCORE_CLR`=1 after edge n+2.
- A button held high produces exactly one start event. Releasing and re-pressing is needed for another.
- `SCORE_INC` to `SCORE` latency is 1 cycle. Back-to-back pulses each count.
- `COLLISION` to LOSE latency is 1 cycle.
- End screen duration is exactly HOLD_CYCLES cycles in WIN/LOSE, counted from the first cycle in that state.
- `SCORE_CLR` is high for exactly one cycle, the first cycle of PLAY.

## Configuration
- Macro: `SNAKE_LOSE_STATE_EN`.
- Defined:
  - The LOSE state exists.
  - `COLLISION` in PLAY moves to LOSE (2'b11), which is held for HOLD_CYCLES and then returns to IDLE.
- Undefined:
  - `COLLISION` is ignored (the port stays present).
  - 2'b11 is never driven.
  - The same-cycle priority rule reduces to the winning `SCORE_INC` always taking effect.

## Structure
- Shared package `snake_pkg` holds:
  - The state encodings `ST_IDLE`, `ST_PLAY`, `ST_WIN`, `ST_LOSE`, used by both this block and the VGA display state machine.
  - The default WIN_SCORE constant.
- Sub-module `button_sync_edge` contains the 2-flop synchronizer, the prev register and the OR-reduced rising-edge detect, parameterized on button count.

## Test plan
1. Reset, then pulse `BTNS`=4'b0001 for 5 cycles. Expected: PLAY exactly 3 edges after the input rises, one-cycle `SCORE_CLR`, `SCORE`=0, and no second start event while held.
2. In PLAY with WIN_SCORE=3, issue 3 back-to-back `SCORE_INC` pulses. Expected: `SCORE` reads 1, 2, 3, and `MASTER_STATE`=WIN on the edge `SCORE` reaches 3.
3. In WIN with HOLD_CYCLES=8, hold buttons high and pulse `SCORE_INC`. Expected: exactly 8 cycles in WIN, then IDLE, with `SCORE` still 3 throughout WIN.
4. With `SNAKE_LOSE_STATE_EN` defined, assert `COLLISION` and a winning `SCORE_INC` in the same cycle. Expected: LOSE (2'b11) and `SCORE` unchanged. With the macro undefined: WIN.
5. Assert `RESET` mid-PLAY with `SCORE`=2. Expected: IDLE and `SCORE`=0 on the next edge, with no `SCORE_CLR` pulse.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared Snake game definitions: master state encodings and default score target.
// Used by master_state_ctrl and the VGA display state machine.
package snake_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_WIN  = 2'b10,
    ST_LOSE = 2'b11
  } state_e;

  localparam int WIN_SCORE_DEF = 10;

endpackage

// File: rtl/master_state_ctrl_if.sv
// Game sequencer bus: buttons and datapath events in, state and score out.
// The master side is the sequencer; the slave side is the snake datapath/display.
interface master_state_ctrl_if;

  logic [3:0] BTNS;
  logic       SCORE_INC;
  logic       COLLISION;
  logic [1:0] MASTER_STATE;
  logic [7:0] SCORE;
  logic       SCORE_CLR;

  modport master (
    input  BTNS,
    input  SCORE_INC,
    input  COLLISION,
    output MASTER_STATE,
    output SCORE,
    output SCORE_CLR
  );

  modport slave (
    output BTNS,
    output SCORE_INC,
    output COLLISION,
    input  MASTER_STATE,
    input  SCORE,
    input  SCORE_CLR
  );

endinterface

// File: rtl/button_sync_edge.sv
// Two-flop synchronizer per button, previous-value register and
// OR-reduced rising-edge detect.
module button_sync_edge #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] btns,
  output logic         edge_o
);

  logic [N-1:0] sync1_q, sync1_d;
  logic [N-1:0] sync2_q, sync2_d;
  logic [N-1:0] prev_q, prev_d;

  always_comb begin
    sync1_d = btns;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign edge_o = |(sync2_q & ~prev_q);

endmodule

// File: rtl/master_state_ctrl.sv
// Snake top-level game sequencer: IDLE -> PLAY -> WIN/LOSE -> IDLE.
// Define SNAKE_LOSE_STATE_EN to enable the LOSE state on COLLISION.
module master_state_ctrl
  import snake_pkg::*;
#(
  parameter int WIN_SCORE   = WIN_SCORE_DEF,
  parameter int HOLD_CYCLES = 100_000_000,
  parameter int HOLD_W      = 27
) (
  input logic CLK,
  input logic RESET,
  master_state_ctrl_if.master bus
);

  localparam logic [7:0] WIN_VAL = 8'(WIN_SCORE);
  localparam logic [7:0] WIN_M1  = 8'(WIN_SCORE - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  state_e            state_q, state_d;
  logic [7:0]        score_q, score_d;
  logic              clr_q, clr_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              btn_edge;

  button_sync_edge #(.N(4)) u_btn (
    .clk    (CLK),
    .rst    (RESET),
    .btns   (bus.BTNS),
    .edge_o (btn_edge)
  );

`ifndef SNAKE_LOSE_STATE_EN
  logic unused_collision;
  assign unused_collision = bus.COLLISION;
`endif

  always_comb begin
    state_d = state_q;
    score_d = score_q;
    clr_d   = 1'b0;
    hold_d  = hold_q;
    unique case (state_q)
      ST_IDLE: begin
        if (btn_edge) begin
          state_d = ST_PLAY;
          score_d = '0;
          clr_d   = 1'b1;
        end
      end
      ST_PLAY: begin
`ifdef SNAKE_LOSE_STATE_EN
        // Collision outranks a same-cycle winning increment
        if (bus.COLLISION) begin
          state_d = ST_LOSE;
          hold_d  = '0;
        end else
`endif
        if (bus.SCORE_INC) begin
          if (score_q == WIN_M1) begin
            state_d = ST_WIN;
            score_d = WIN_VAL;
            hold_d  = '0;
          end else if (score_q != WIN_VAL) begin
            score_d = score_q + 8'd1;
          end
        end
      end
      default: begin
        if (hold_q == HOLD_LAST) begin
          state_d = ST_IDLE;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      score_q <= '0;
      clr_q   <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      clr_q   <= clr_d;
      hold_q  <= hold_d;
    end
  end

  assign bus.MASTER_STATE = state_q;
  assign bus.SCORE        = score_q;
  assign bus.SCORE_CLR    = clr_q;

endmodule

// File: tb/tb_master_state_ctrl.sv
// Directed bench for master_state_ctrl with WIN_SCORE=3, HOLD_CYCLES=8.
module tb_master_state_ctrl;

  logic CLK;
  logic RESET;
  int   vectors;
  int   miscompares;

  master_state_ctrl_if bus ();

  master_state_ctrl #(
    .WIN_SCORE   (3),
    .HOLD_CYCLES (8),
    .HOLD_W      (4)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.master)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    bus.BTNS = 4'b0000;
    bus.SCORE_INC = 1'b0;
    bus.COLLISION = 1'b0;
    tick();
    tick();
    RESET = 1'b0;
    vectors++;
    if (bus.MASTER_STATE !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_state: got %b want 00", bus.MASTER_STATE);
    end
    vectors++;
    if (bus.SCORE !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_score: got %0d want 0", bus.SCORE);
    end
    vectors++;
    if (bus.SCORE_CLR !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_clr: got %b want 0", bus.SCORE_CLR);
    end
  endtask

  task automatic test_start();
    bus.BTNS = 4'b0001;
    tick();
    tick();
    vectors++;
    if (bus.MASTER_STATE !== 2'b00) begin
      miscompares++;
      $display("FAIL start_early: got %b want 00", bus.MASTER_STATE);
    end
    tick();
    vectors++;
    if (bus.MASTER_STATE !== 2'b01) begin
      miscompares++;
      $display("FAIL start_play: got %b want 01", bus.MASTER_STATE);
    end
    vectors++;
    if (bus.SCORE_CLR !== 1'b1) begin
      miscompares++;
      $display("FAIL start_clr: got %b want 1", bus.SCORE_CLR);
    end
    vectors++;
    if (bus.SCORE !== 8'd0) begin
      miscompares++;
      $display("FAIL start_score: got %0d want 0", bus.SCORE);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if (bus.SCORE_CLR !== 1'b0 || bus.MASTER_STATE !== 2'b01) begin
        miscompares++;
        $display("FAIL start_held: clr %b state %b want 0 01",
                 bus.SCORE_CLR, bus.MASTER_STATE);
      end
    end
    bus.BTNS = 4'b0000;
  endtask

  task automatic test_score();
    logic [7:0] exp_s [3];
    logic [1:0] exp_st [3];
    exp_s  = '{8'd1, 8'd2, 8'd3};
    exp_st = '{2'b01, 2'b01, 2'b10};
    bus.SCORE_INC = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (bus.SCORE !== exp_s[i] || bus.MASTER_STATE !== exp_st[i]) begin
        miscompares++;
        $display("FAIL score_inc%0d: score %0d state %b want %0d %b",
                 i, bus.SCORE, bus.MASTER_STATE, exp_s[i], exp_st[i]);
      end
    end
    bus.SCORE_INC = 1'b0;
  endtask

  task automatic test_hold();
    bus.BTNS = 4'b1111;
    bus.SCORE_INC = 1'b1;
    for (int i = 1; i < 8; i++) begin
      tick();
      vectors++;
      if (bus.MASTER_STATE !== 2'b10 || bus.SCORE !== 8'd3) begin
        miscompares++;
        $display("FAIL hold_win%0d: state %b score %0d want 10 3",
                 i, bus.MASTER_STATE, bus.SCORE);
      end
    end
    tick();
    vectors++;
    if (bus.MASTER_STATE !== 2'b00 || bus.SCORE !== 8'd3) begin
      miscompares++;
      $display("FAIL hold_exit: state %b score %0d want 00 3",
               bus.MASTER_STATE, bus.SCORE);
    end
    tick();
    vectors++;
    if (bus.MASTER_STATE !== 2'b00) begin
      miscompares++;
      $display("FAIL hold_btn_held: state %b want 00", bus.MASTER_STATE);
    end
    bus.BTNS = 4'b0000;
    bus.SCORE_INC = 1'b0;
    tick();
    tick();
    tick();
  endtask

  task automatic start_game(input logic [3:0] b);
    bus.BTNS = b;
    tick();
    tick();
    tick();
    bus.BTNS = 4'b0000;
  endtask

  task automatic test_collision_priority();
    logic [1:0] exp_st;
    logic [7:0] exp_s;
    start_game(4'b0100);
    vectors++;
    if (bus.MASTER_STATE !== 2'b01 || bus.SCORE !== 8'd0) begin
      miscompares++;
      $display("FAIL col_start: state %b score %0d want 01 0",
               bus.MASTER_STATE, bus.SCORE);
    end
    bus.SCORE_INC = 1'b1;
    tick();
    tick();
    bus.COLLISION = 1'b1;
    tick();
    bus.COLLISION = 1'b0;
    bus.SCORE_INC = 1'b0;
`ifdef SNAKE_LOSE_STATE_EN
    exp_st = 2'b11;
    exp_s  = 8'd2;
`else
    exp_st = 2'b10;
    exp_s  = 8'd3;
`endif
    vectors++;
    if (bus.MASTER_STATE !== exp_st || bus.SCORE !== exp_s) begin
      miscompares++;
      $display("FAIL col_priority: state %b score %0d want %b %0d",
               bus.MASTER_STATE, bus.SCORE, exp_st, exp_s);
    end
    for (int i = 0; i < 8; i++) tick();
    vectors++;
    if (bus.MASTER_STATE !== 2'b00) begin
      miscompares++;
      $display("FAIL col_return: state %b want 00", bus.MASTER_STATE);
    end
  endtask

  task automatic test_reset_mid_play();
    start_game(4'b1000);
    bus.SCORE_INC = 1'b1;
    tick();
    tick();
    bus.SCORE_INC = 1'b0;
    vectors++;
    if (bus.MASTER_STATE !== 2'b01 || bus.SCORE !== 8'd2) begin
      miscompares++;
      $display("FAIL rst_setup: state %b score %0d want 01 2",
               bus.MASTER_STATE, bus.SCORE);
    end
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    vectors++;
    if (bus.MASTER_STATE !== 2'b00 || bus.SCORE !== 8'd0) begin
      miscompares++;
      $display("FAIL rst_mid: state %b score %0d want 00 0",
               bus.MASTER_STATE, bus.SCORE);
    end
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (bus.SCORE_CLR !== 1'b0) begin
        miscompares++;
        $display("FAIL rst_noclr%0d: got %b want 0", i, bus.SCORE_CLR);
      end
      tick();
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    RESET = 1'b1;
    bus.BTNS = 4'b0000;
    bus.SCORE_INC = 1'b0;
    bus.COLLISION = 1'b0;
    #2;
    test_reset();
    test_start();
    test_score();
    test_hold();
    test_collision_priority();
    test_reset_mid_play();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
